// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad reader.
//
// Holds the scan FSM state enumeration, the active-low column drive patterns,
// the key code width and small helpers that map between column patterns,
// column indices, row vectors and key codes.
package keypad_pkg;

  // Key code is row * 4 + col, so two bits of row and two bits of column.
  localparam int unsigned CodeWidth = 4;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } key_state_e;

  // Column drive patterns: exactly one column pulled low.
  localparam logic [3:0] Col0 = 4'b1110;
  localparam logic [3:0] Col1 = 4'b1101;
  localparam logic [3:0] Col2 = 4'b1011;
  localparam logic [3:0] Col3 = 4'b0111;

  // Rows are pulled up, so no key on the driven column reads as all ones.
  localparam logic [3:0] AllRowsHigh = 4'hF;

  // Rotate the low bit one place up, wrapping column 3 back to column 0.
  function automatic logic [3:0] next_col(input logic [3:0] col_n);
    return {col_n[2:0], col_n[3]};
  endfunction

  // Index of the single low bit in a column drive pattern.
  function automatic logic [1:0] col_index(input logic [3:0] col_n);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (col_n)
      Col0:    idx = 2'd0;
      Col1:    idx = 2'd1;
      Col2:    idx = 2'd2;
      Col3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest-index row that reads low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    if (!rows_n[0]) begin
      idx = 2'd0;
    end else if (!rows_n[1]) begin
      idx = 2'd1;
    end else if (!rows_n[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [CodeWidth-1:0] key_code_of(input logic [1:0] row,
                                                       input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick generator for the keypad reader.
//
// A free-running counter of SCAN_DIV_BITS bits; tick is high for the single
// clock cycle in which the counter holds all ones, giving one tick every
// 2^SCAN_DIV_BITS clocks.
//
// Ports:
//   clock  - sole clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the counter
//   tick   - one-cycle scan strobe
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV_BITS = 15
) (
  input  logic clock,
  input  logic rst_n,
  output logic tick
);

  logic [SCAN_DIV_BITS-1:0] count_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick = &count_q;

endmodule

// File: rtl/matrix_keypad_reader.sv
// 4x4 matrix keypad reader with debounce and a CPU read interface.
//
// Drives one column low at a time, rotating on each scan tick while no row
// reads low. A low row starts a debounce on that row/column; after
// DEBOUNCE_SCANS consecutive low samples the key is accepted once and the
// scanner parks on that column until the keypad has read all-high for
// DEBOUNCE_SCANS consecutive ticks. There is no auto-repeat.
//
// Ports:
//   clock         - sole clock, rising edge
//   rst_n         - asynchronous active-low reset
//   chip_select   - CPU read strobe, clears key_valid / key_overflow
//   row_input     - keypad rows, active-low, asynchronous
//   col_output    - column drive, exactly one bit low
//   key_code      - last accepted key (row * 4 + col)
//   key_data      - last eight accepted codes as nibbles, newest in [3:0]
//   key_valid     - sticky: an unacknowledged key is pending
//   key_overflow  - sticky: a key was accepted while one was already pending
module matrix_keypad_reader
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV_BITS  = 15,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 chip_select,
  input  logic [3:0]           row_input,
  output logic [3:0]           col_output,
  output logic [CodeWidth-1:0] key_code,
  output logic [31:0]          key_data,
  output logic                 key_valid,
  output logic                 key_overflow
);

  // The detection sample counts as the first low sample, so acceptance comes
  // when the counter of further low samples reaches DEBOUNCE_SCANS - 1.
  localparam logic [3:0] PressLast   = 4'(DEBOUNCE_SCANS - 1);
  localparam logic [3:0] ReleaseLast = 4'(DEBOUNCE_SCANS);

  // ---------------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta_q;
  logic [3:0] row_sync_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= AllRowsHigh;
      row_sync_q <= AllRowsHigh;
    end else begin
      row_meta_q <= row_input;
      row_sync_q <= row_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan tick
  // ---------------------------------------------------------------------------
  logic tick;

  scan_tick_gen #(
    .SCAN_DIV_BITS (SCAN_DIV_BITS)
  ) u_scan_tick_gen (
    .clock (clock),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------------------
  key_state_e state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [3:0] count_q, count_d;
  logic [3:0] count_inc;
  logic       rows_idle;
  logic       accept;

  assign count_inc = count_q + 4'd1;
  assign rows_idle = (row_sync_q == AllRowsHigh);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    count_d = count_q;
    accept  = 1'b0;

    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (rows_idle) begin
            col_d = next_col(col_q);
          end else begin
            // Column is left where it is so the captured key stays driven.
            row_d   = lowest_low_row(row_sync_q);
            count_d = '0;
            state_d = StDebounce;
          end
        end

        StDebounce: begin
          if (!row_sync_q[row_q]) begin
            count_d = count_inc;
            if (count_inc == PressLast) begin
              accept  = 1'b1;
              state_d = StHeld;
            end
          end else begin
            state_d = StScan;
            col_d   = next_col(col_q);
          end
        end

        StHeld: begin
          // Any low row keeps us here: other keys are ignored until release.
          if (rows_idle) begin
            count_d = 4'd1;
            state_d = StRelease;
          end
        end

        StRelease: begin
          if (rows_idle) begin
            count_d = count_inc;
            if (count_inc == ReleaseLast) begin
              state_d = StScan;
              col_d   = next_col(col_q);
            end
          end else begin
            state_d = StHeld;
          end
        end

        default: begin
          state_d = StScan;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StScan;
      col_q   <= Col0;
      row_q   <= 2'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      count_q <= count_d;
    end
  end

  assign col_output = col_q;

  // ---------------------------------------------------------------------------
  // CPU-visible key registers
  // ---------------------------------------------------------------------------
  logic [CodeWidth-1:0] accept_code;
  logic [CodeWidth-1:0] key_code_q, key_code_d;
  logic [31:0]          key_data_q, key_data_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_overflow_q, key_overflow_d;

  assign accept_code = key_code_of(row_q, col_index(col_q));

  always_comb begin
    key_code_d     = key_code_q;
    key_data_d     = key_data_q;
    key_valid_d    = key_valid_q;
    key_overflow_d = key_overflow_q;

    if (chip_select) begin
      key_valid_d    = 1'b0;
      key_overflow_d = 1'b0;
    end

    // Acceptance overrides a simultaneous read; overflow then reflects
    // whether a key was still pending before this one.
    if (accept) begin
      key_code_d     = accept_code;
      key_data_d     = {key_data_q[31-CodeWidth:0], accept_code};
      key_valid_d    = 1'b1;
      key_overflow_d = key_valid_q | (key_overflow_q & ~chip_select);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q     <= '0;
      key_data_q     <= '0;
      key_valid_q    <= 1'b0;
      key_overflow_q <= 1'b0;
    end else begin
      key_code_q     <= key_code_d;
      key_data_q     <= key_data_d;
      key_valid_q    <= key_valid_d;
      key_overflow_q <= key_overflow_d;
    end
  end

  assign key_code     = key_code_q;
  assign key_data     = key_data_q;
  assign key_valid    = key_valid_q;
  assign key_overflow = key_overflow_q;

endmodule

// File: tb/tb_matrix_keypad_reader.sv
// Testbench for matrix_keypad_reader (SCAN_DIV_BITS = 4, DEBOUNCE_SCANS = 3).
//
// A physical keypad model turns a mask of pressed keys plus the driven column
// into row levels. A reference model advances once per scan tick from the
// keypad mask and keeps the accepted-key history as a queue and the pending
// read count as an integer; every clock the DUT outputs are compared to it.
// Directed sequences add literal expectations, then random key masks,
// chip_select pulses and resets follow.
module tb_matrix_keypad_reader;

  localparam int unsigned DivBits = 4;
  localparam int          Deb     = 3;
  localparam int          Period  = 16;

  localparam int ModeScan    = 0;
  localparam int ModeConfirm = 1;
  localparam int ModeHeld    = 2;
  localparam int ModeRelease = 3;

  logic        clock       = 1'b0;
  logic        rst_n       = 1'b0;
  logic        chip_select = 1'b0;
  logic [3:0]  row_input;
  logic [3:0]  col_output;
  logic [3:0]  key_code;
  logic [31:0] key_data;
  logic        key_valid;
  logic        key_overflow;

  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Row r reads low when a pressed key of row r sits on a driven column.
  always_comb begin
    row_input = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_output[c]) row_input[r] = 1'b0;
      end
    end
  end

  matrix_keypad_reader #(
    .SCAN_DIV_BITS  (DivBits),
    .DEBOUNCE_SCANS (Deb)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .chip_select  (chip_select),
    .row_input    (row_input),
    .col_output   (col_output),
    .key_code     (key_code),
    .key_data     (key_data),
    .key_valid    (key_valid),
    .key_overflow (key_overflow)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_col       = 0;
  int m_mode      = ModeScan;
  int m_row       = 0;
  int m_run       = 0;
  int m_pending   = 0;
  int m_ncyc      = 0;
  int tick_count  = 0;
  int hist[$];

  function automatic int lowest_row(input int c);
    for (int r = 0; r < 4; r++) begin
      if (pressed[r*4+c]) return r;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge rst_n) begin : ref_model
    bit is_tick;
    bit acc;
    int code;
    int low;
    if (!rst_n) begin
      m_col     = 0;
      m_mode    = ModeScan;
      m_row     = 0;
      m_run     = 0;
      m_pending = 0;
      m_ncyc    = 0;
      hist.delete();
    end else begin
      is_tick = (m_ncyc % Period) == Period - 1;
      acc     = 1'b0;
      code    = 0;
      m_ncyc++;
      if (is_tick) begin
        tick_count++;
        low = lowest_row(m_col);
        case (m_mode)
          ModeScan: begin
            if (low < 0) begin
              m_col = (m_col + 1) % 4;
            end else begin
              m_row  = low;
              m_run  = 1;
              m_mode = ModeConfirm;
            end
          end
          ModeConfirm: begin
            if (pressed[m_row*4+m_col]) begin
              m_run++;
              if (m_run == Deb) begin
                acc    = 1'b1;
                code   = m_row * 4 + m_col;
                m_mode = ModeHeld;
              end
            end else begin
              m_mode = ModeScan;
              m_col  = (m_col + 1) % 4;
            end
          end
          ModeHeld: begin
            if (low < 0) begin
              m_run  = 1;
              m_mode = ModeRelease;
            end
          end
          ModeRelease: begin
            if (low < 0) begin
              m_run++;
              if (m_run == Deb) begin
                m_mode = ModeScan;
                m_col  = (m_col + 1) % 4;
              end
            end else begin
              m_mode = ModeHeld;
            end
          end
          default: ;
        endcase
      end
      if (acc) begin
        hist.push_back(code);
        if (hist.size() > 8) void'(hist.pop_front());
        m_pending = (m_pending > 0) ? 2 : 1;
      end else if (chip_select) begin
        m_pending = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  e_col;
    logic [31:0] e_data;
    logic [3:0]  e_code;
    int          n;
    e_col        = 4'hF;
    e_col[m_col] = 1'b0;
    e_data       = '0;
    n            = hist.size();
    for (int j = 0; j < n; j++) begin
      e_data = e_data | (32'(hist[n-1-j]) << (4 * j));
    end
    e_code = (n > 0) ? 4'(hist[n-1]) : 4'h0;
    check("col_output", 32'(col_output), 32'(e_col));
    check("key_code", 32'(key_code), 32'(e_code));
    check("key_data", key_data, e_data);
    check("key_valid", 32'(key_valid), 32'(m_pending >= 1));
    check("key_overflow", 32'(key_overflow), 32'(m_pending >= 2));
  endtask

  task automatic step();
    @(negedge clock);
    check_outputs();
  endtask

  // Advance k scan ticks, optionally pulsing chip_select at random.
  task automatic wait_ticks(input int k, input int cs_pct);
    int target;
    int guard;
    target = tick_count + k;
    guard  = 0;
    while (tick_count < target && guard < Period * k + 40) begin
      chip_select = ($urandom_range(99) < cs_pct);
      step();
      guard++;
    end
    chip_select = 1'b0;
    if (tick_count < target) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got %0d ticks, expected %0d", tick_count, target);
    end
  endtask

  task automatic wait_col(input int c);
    int guard;
    guard = 0;
    while (!(m_mode == ModeScan && m_col == c) && guard < 16) begin
      wait_ticks(1, 0);
      guard++;
    end
    if (!(m_mode == ModeScan && m_col == c)) begin
      checks++;
      errors++;
      $display("FAIL wait_col: got column %0d, expected %0d", m_col, c);
    end
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    step();
    step();
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic press_accept(input int code);
    wait_col(code % 4);
    pressed = 16'(1) << code;
    wait_ticks(Deb, 0);
    pressed = '0;
    wait_ticks(Deb, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] scan_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int guard;
    int nk;
    step();
    step();
    #3 rst_n = 1'b1;
    step();

    // Idle scan after reset.
    check("lit_reset_col", 32'(col_output), 32'h0000000e);
    check("lit_reset_valid", 32'(key_valid), 32'h0);
    for (int i = 1; i < 5; i++) begin
      wait_ticks(1, 0);
      check("lit_scan_col", 32'(col_output), 32'(scan_seq[i]));
      check("lit_scan_data", key_data, 32'h0);
    end

    // Key 9 (row 2, column 1) held for six ticks.
    wait_col(1);
    pressed = 16'(1) << 9;
    wait_ticks(2, 0);
    check("lit_k9_not_yet", 32'(key_valid), 32'h0);
    check("lit_k9_col_held", 32'(col_output), 32'h0000000d);
    wait_ticks(1, 0);
    check("lit_k9_code", 32'(key_code), 32'h9);
    check("lit_k9_data", key_data, 32'h00000009);
    check("lit_k9_valid", 32'(key_valid), 32'h1);
    wait_ticks(3, 0);
    pressed = '0;
    wait_ticks(2, 0);
    check("lit_k9_release_col", 32'(col_output), 32'h0000000d);
    wait_ticks(1, 0);
    check("lit_k9_resume_col", 32'(col_output), 32'h0000000b);

    // Two-tick press of key 9 is rejected.
    chip_select = 1'b1;
    step();
    chip_select = 1'b0;
    wait_col(1);
    pressed = 16'(1) << 9;
    wait_ticks(2, 0);
    pressed = '0;
    wait_ticks(1, 0);
    check("lit_short_col", 32'(col_output), 32'h0000000b);
    check("lit_short_valid", 32'(key_valid), 32'h0);
    check("lit_short_data", key_data, 32'h00000009);

    // Keys 1, 2, 3 without reads, then a read.
    do_reset();
    wait_ticks(1, 0);
    press_accept(1);
    press_accept(2);
    press_accept(3);
    check("lit_123_data", key_data, 32'h00000123);
    check("lit_123_ovf", 32'(key_overflow), 32'h1);
    chip_select = 1'b1;
    step();
    chip_select = 1'b0;
    step();
    check("lit_read_valid", 32'(key_valid), 32'h0);
    check("lit_read_ovf", 32'(key_overflow), 32'h0);
    check("lit_read_data", key_data, 32'h00000123);
    check("lit_read_code", 32'(key_code), 32'h3);

    // Read strobe in the same cycle as accepting key 5 with key 4 pending.
    press_accept(4);
    check("lit_k4_ovf", 32'(key_overflow), 32'h0);
    wait_col(1);
    pressed = 16'(1) << 5;
    wait_ticks(Deb - 1, 0);
    guard = 0;
    while ((m_ncyc % Period) != Period - 1 && guard < 20) begin
      step();
      guard++;
    end
    chip_select = 1'b1;
    step();
    chip_select = 1'b0;
    check("lit_k5_valid", 32'(key_valid), 32'h1);
    check("lit_k5_ovf", 32'(key_overflow), 32'h1);
    check("lit_k5_code", 32'(key_code), 32'h5);
    pressed = '0;
    wait_ticks(Deb, 0);

    // Reset while key 7 is held; it must be accepted once more afterwards.
    do_reset();
    wait_ticks(1, 0);
    wait_col(3);
    pressed = 16'(1) << 7;
    wait_ticks(Deb + 1, 0);
    do_reset();
    check("lit_rst_code", 32'(key_code), 32'h0);
    check("lit_rst_data", key_data, 32'h0);
    check("lit_rst_valid", 32'(key_valid), 32'h0);
    check("lit_rst_col", 32'(col_output), 32'h0000000e);
    wait_ticks(10, 0);
    check("lit_k7_data", key_data, 32'h00000007);
    check("lit_k7_valid", 32'(key_valid), 32'h1);
    check("lit_k7_ovf", 32'(key_overflow), 32'h0);
    pressed = '0;
    wait_ticks(Deb + 1, 0);

    // Random key masks, read strobes and occasional resets.
    for (int it = 0; it < 200; it++) begin
      nk = $urandom_range(9);
      if (nk < 4) begin
        pressed = '0;
      end else if (nk < 8) begin
        pressed = 16'(1) << $urandom_range(15);
      end else begin
        pressed = (16'(1) << $urandom_range(15)) | (16'(1) << $urandom_range(15));
      end
      wait_ticks($urandom_range(6, 1), 4);
      if ($urandom_range(39) == 0) begin
        do_reset();
        wait_ticks(1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_keypad_reader.md
MATRIX_KEYPAD_READER -- requirements
Module: matrix_keypad_reader

Interface
REQ-001 Parameter SCAN_DIV_BITS, default 15, SHALL set the scan tick period to 2^SCAN_DIV_BITS clocks.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, range 2..15, SHALL set the number of consecutive scan ticks needed to accept a press or release.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 chip_select  input  1  CPU read strobe; acknowledges the pending key.
REQ-006 row_input  input  4  keypad rows, active-low, externally pulled up, asynchronous to clock.
REQ-007 col_output  output  4  column drive, exactly one bit low at all times.
REQ-008 key_code  output  4  last accepted key, code = row*4 + col.
REQ-009 key_data  output  32  last 8 accepted codes packed as nibbles, newest in [3:0]; directly displayable.
REQ-010 key_valid  output  1  sticky: an unacknowledged key is pending.
REQ-011 key_overflow  output  1  sticky: a key was accepted while key_valid was already 1.

Function
REQ-012 row_input SHALL pass through a 2-flop synchronizer (reset value 4'hF) before any use.
REQ-013 A free-running counter SHALL assert a one-cycle tick when it equals all ones; sampling and column changes SHALL occur only on tick cycles.
REQ-014 States: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: on tick, if synchronized rows == 4'hF, col_output SHALL rotate to the next column (0->1->2->3->0 wrap); otherwise capture column and lowest-index low row, clear debounce count, go DEBOUNCE, column held.
REQ-016 DEBOUNCE: on tick, if the captured row is still low, count+1; if it is high, go SCAN and advance the column.
REQ-017 When the press count reaches DEBOUNCE_SCANS-1 (DEBOUNCE_SCANS total low samples including detection), on that tick the key SHALL be accepted and the FSM SHALL go HELD.
REQ-018 Acceptance (registered, visible the clock after the tick): key_code <= code; key_data <= {key_data[27:0], code}; key_valid <= 1; key_overflow <= 1 if key_valid was 1.
REQ-019 HELD: on tick, if all rows high, go RELEASE with count 1; otherwise stay (no auto-repeat, other keys ignored).
REQ-020 RELEASE: on tick, rows all high -> count+1; any row low -> back to HELD; count reaching DEBOUNCE_SCANS -> go SCAN and advance column.
REQ-021 chip_select high for one clock SHALL clear key_valid and key_overflow on the next edge.
REQ-022 Acceptance and chip_select in the same cycle: acceptance wins; key_valid = 1, key_overflow = old key_valid value.
REQ-023 key_data and key_code SHALL NOT change on chip_select.
REQ-024 col_output SHALL be registered and glitch-free; exactly one zero bit in every state.

Reset
REQ-025 On rst_n low, immediately: counter 0, state SCAN, col_output 4'b1110, key_code 0, key_data 0, key_valid 0, key_overflow 0, synchronizer 4'hF.
REQ-026 Reset mid-debounce or mid-hold SHALL discard the key in progress; after release of reset, a still-pressed key SHALL be re-detected and accepted once, after full debounce.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enumeration, the column one-hot-low constants, and the code formula width (4).
REQ-028 Sub-module scan_tick_gen (counter + tick, parameter SCAN_DIV_BITS) SHALL be separate; the rest is one module.

Verification (SCAN_DIV_BITS=4, DEBOUNCE_SCANS=3, tick every 16 clocks)
REQ-029 Reset release, no key -> col_output cycles 1110,1101,1011,0111,1110 every 16 clocks; all outputs stay 0.
REQ-030 Hold row 2 low while column 1 is driven, for 6 ticks -> key_code 9, key_data 0x00000009, key_valid 1 after the 3rd low sample; col_output frozen at 1101 until 3 high ticks after release.
REQ-031 Press code 9 for only 2 ticks -> no acceptance, key_valid 0, scan resumes at column 2.
REQ-032 Accept keys 1,2,3 without chip_select -> key_data 0x00000123, key_overflow 1; then chip_select -> key_valid 0, key_overflow 0, key_data unchanged.
REQ-033 chip_select in the accept cycle of key 5 with key_valid=1 -> key_valid 1, key_overflow 1.
REQ-034 rst_n low during HELD of key 7, key still pressed after release of reset -> all outputs 0, then key 7 accepted exactly once after 3 ticks.
